gon_tag_sequencer: RTL and testbench

Generates the (row, col) tag stream that drives the global-on-chip-network gather FIFO's tag write port. Given a rectangular region of the PE array and a pass count, it walks every row/col tag pair in a fixed scan order, writes one tag per cycle whenever the tag FIFO is not full, and signals completion. It sits directly upstream of the GON FIFO's tag input, under control of the top-level sequencer.

---
 rtl/gon_pkg.sv | 30 +++
 rtl/gon_tag_sequencer_if.sv | 33 +++
 rtl/gon_tag_counter.sv | 41 ++++
 rtl/gon_tag_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_gon_tag_sequencer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gon_pkg.sv
// gon_pkg: shared types for the global-on-chip-network tag path.
//   gon_tag_seq_state_t : sequencer FSM states (IDLE, RUN, DONE)
//   gon_tag_pair_t      : one FIFO tag word, col in the MSBs, row in the LSBs
//   gon_sat_inc32       : saturating +1 used by the optional performance counters
package gon_pkg;

  localparam int GON_ROW_TAG_WIDTH = 4;
  localparam int GON_COL_TAG_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gon_tag_seq_state_t;

  typedef struct packed {
    logic [GON_COL_TAG_WIDTH-1:0] col;
    logic [GON_ROW_TAG_WIDTH-1:0] row;
  } gon_tag_pair_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] gon_sat_inc32(input logic [31:0] value);
    if (value == 32'hFFFF_FFFF) begin
      return value;
    end else begin
      return value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/gon_tag_sequencer_if.sv
// gon_tag_sequencer_if: tag write port between the tag sequencer and the GON
// gather FIFO.
//   row_tag, col_tag : tag pair presented to the FIFO
//   tags_wr_en       : write strobe (never asserted while tags_full is high)
//   tags_full        : FIFO full flag
// Modports: master = sequencer side, slave = FIFO side.
interface gon_tag_sequencer_if
  import gon_pkg::*;
#(
  parameter int ROW_TAG_WIDTH = 4,
  parameter int COL_TAG_WIDTH = 4
);

  logic [ROW_TAG_WIDTH-1:0] row_tag;
  logic [COL_TAG_WIDTH-1:0] col_tag;
  logic                     tags_wr_en;
  logic                     tags_full;

  modport master (
    output row_tag,
    output col_tag,
    output tags_wr_en,
    input  tags_full
  );

  modport slave (
    input  row_tag,
    input  col_tag,
    input  tags_wr_en,
    output tags_full
  );

endinterface

// File: rtl/gon_tag_counter.sv
// gon_tag_counter: wrap counter that runs 0 .. cnt-1 and flags the last value.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : synchronous return to 0 (wins over inc)
//   inc        : advance by one, wrapping to 0 after the last value
//   cnt        : number of values in the cycle (callers never use it while 0)
//   last       : value is cnt-1; chain into the next counter's inc
module gon_tag_counter
  import gon_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [WIDTH-1:0] cnt,
  output logic             last
);

  logic [WIDTH-1:0] value_r;

  assign last = (value_r == (cnt - WIDTH'(1)));

  // Counter state: clear, wrap on last, or hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_r <= {WIDTH{1'b0}};
    end else if (clear) begin
      value_r <= {WIDTH{1'b0}};
    end else if (inc) begin
      if (last) begin
        value_r <= {WIDTH{1'b0}};
      end else begin
        value_r <= value_r + WIDTH'(1);
      end
    end else begin
      value_r <= value_r;
    end
  end

endmodule

// File: rtl/gon_tag_sequencer.sv
// gon_tag_sequencer: walks every (row, col) tag of a rectangular PE region for
// a number of passes (col inner, row middle, pass outer) and writes one tag per
// cycle into the GON gather FIFO whenever it is not full.
//   clk, reset           : clock, asynchronous active-low reset
//   start, abort         : job request (IDLE only) and synchronous cancel
//   cfg_row_base/_cnt    : first row tag and rows per pass
//   cfg_col_base/_cnt    : first col tag and cols per pass
//   cfg_passes           : passes over the region (any zero count => no writes)
//   tags                 : FIFO tag write port (gon_tag_sequencer_if.master)
//   busy                 : high while tags are being issued
//   done                 : one-cycle completion pulse (not pulsed on abort)
// Optional macro GON_TAG_SEQ_PERF_EN adds perf_stall_cnt / perf_tag_cnt.
module gon_tag_sequencer
  import gon_pkg::*;
#(
  parameter int ROW_TAG_WIDTH = 4,
  parameter int COL_TAG_WIDTH = 4,
  parameter int PASS_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ROW_TAG_WIDTH-1:0] cfg_row_base,
  input  logic [ROW_TAG_WIDTH:0]   cfg_row_cnt,
  input  logic [COL_TAG_WIDTH-1:0] cfg_col_base,
  input  logic [COL_TAG_WIDTH:0]   cfg_col_cnt,
  input  logic [PASS_WIDTH-1:0]    cfg_passes,
  gon_tag_sequencer_if.master      tags,
  output logic                     busy,
  output logic                     done
`ifdef GON_TAG_SEQ_PERF_EN
  ,
  output logic [31:0]              perf_stall_cnt,
  output logic [31:0]              perf_tag_cnt
`endif
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]               state_r;
  logic [1:0]               state_nxt_s;
  logic [ROW_TAG_WIDTH-1:0] row_base_r;
  logic [ROW_TAG_WIDTH:0]   row_cnt_r;
  logic [COL_TAG_WIDTH-1:0] col_base_r;
  logic [COL_TAG_WIDTH:0]   col_cnt_r;
  logic [PASS_WIDTH-1:0]    passes_r;
  logic [ROW_TAG_WIDTH-1:0] row_tag_r;
  logic [COL_TAG_WIDTH-1:0] col_tag_r;
  logic wr_en_s, accept_s, zero_cnt_s;
  logic col_last_s, row_last_s, pass_last_s;
  logic row_inc_s, pass_inc_s, last_wr_s;

  // Write strobe, start acceptance and the counter carry chain.
  // The abort term keeps the cancel cycle itself from issuing a write.
  always_comb begin
    wr_en_s    = (state_r == S_RUN) & ~tags.tags_full & ~abort;
    accept_s   = (state_r == S_IDLE) & start & ~abort;
    zero_cnt_s = (cfg_row_cnt == {(ROW_TAG_WIDTH+1){1'b0}}) |
                 (cfg_col_cnt == {(COL_TAG_WIDTH+1){1'b0}}) |
                 (cfg_passes  == {PASS_WIDTH{1'b0}});
    row_inc_s  = wr_en_s & col_last_s;
    pass_inc_s = row_inc_s & row_last_s;
    last_wr_s  = pass_inc_s & pass_last_s;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if (zero_cnt_s) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s = S_RUN;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nxt_s = S_IDLE;
        end else if (last_wr_s) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Shadow copy of the job configuration, captured only on an accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_base_r <= {ROW_TAG_WIDTH{1'b0}};
      row_cnt_r  <= {(ROW_TAG_WIDTH+1){1'b0}};
      col_base_r <= {COL_TAG_WIDTH{1'b0}};
      col_cnt_r  <= {(COL_TAG_WIDTH+1){1'b0}};
      passes_r   <= {PASS_WIDTH{1'b0}};
    end else if (accept_s) begin
      row_base_r <= cfg_row_base;
      row_cnt_r  <= cfg_row_cnt;
      col_base_r <= cfg_col_base;
      col_cnt_r  <= cfg_col_cnt;
      passes_r   <= cfg_passes;
    end else begin
      row_base_r <= row_base_r;
      row_cnt_r  <= row_cnt_r;
      col_base_r <= col_base_r;
      col_cnt_r  <= col_cnt_r;
      passes_r   <= passes_r;
    end
  end

  // Tag registers track base+offset incrementally; the adds wrap modulo
  // 2^width by construction, and the tags hold while the FIFO is full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_tag_r <= {ROW_TAG_WIDTH{1'b0}};
      col_tag_r <= {COL_TAG_WIDTH{1'b0}};
    end else if (accept_s) begin
      row_tag_r <= cfg_row_base;
      col_tag_r <= cfg_col_base;
    end else if (wr_en_s) begin
      if (col_last_s) begin
        col_tag_r <= col_base_r;
        if (row_last_s) begin
          row_tag_r <= row_base_r;
        end else begin
          row_tag_r <= row_tag_r + ROW_TAG_WIDTH'(1);
        end
      end else begin
        col_tag_r <= col_tag_r + COL_TAG_WIDTH'(1);
        row_tag_r <= row_tag_r;
      end
    end else begin
      row_tag_r <= row_tag_r;
      col_tag_r <= col_tag_r;
    end
  end

  gon_tag_counter #(.WIDTH(COL_TAG_WIDTH+1)) u_col_cnt (
    .clk(clk), .reset(reset), .clear(accept_s), .inc(wr_en_s),
    .cnt(col_cnt_r), .last(col_last_s)
  );

  gon_tag_counter #(.WIDTH(ROW_TAG_WIDTH+1)) u_row_cnt (
    .clk(clk), .reset(reset), .clear(accept_s), .inc(row_inc_s),
    .cnt(row_cnt_r), .last(row_last_s)
  );

  gon_tag_counter #(.WIDTH(PASS_WIDTH)) u_pass_cnt (
    .clk(clk), .reset(reset), .clear(accept_s), .inc(pass_inc_s),
    .cnt(passes_r), .last(pass_last_s)
  );

  assign tags.row_tag    = row_tag_r;
  assign tags.col_tag    = col_tag_r;
  assign tags.tags_wr_en = wr_en_s;
  assign busy            = (state_r == S_RUN);
  assign done            = (state_r == S_DONE);

`ifdef GON_TAG_SEQ_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] tag_cnt_r;

  // Stall and write counters: cleared per job, saturating, held afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= 32'd0;
      tag_cnt_r   <= 32'd0;
    end else if (accept_s) begin
      stall_cnt_r <= 32'd0;
      tag_cnt_r   <= 32'd0;
    end else begin
      if ((state_r == S_RUN) && tags.tags_full) begin
        stall_cnt_r <= gon_sat_inc32(stall_cnt_r);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (wr_en_s) begin
        tag_cnt_r <= gon_sat_inc32(tag_cnt_r);
      end else begin
        tag_cnt_r <= tag_cnt_r;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_r;
  assign perf_tag_cnt   = tag_cnt_r;
`endif

endmodule

// File: tb/tb_gon_tag_sequencer.sv
// tb_gon_tag_sequencer: directed bench for gon_tag_sequencer. A queue of
// expected tag pairs is built from nested pass/row/col loops and checked
// against every FIFO write; job-level timing and literal tag tables are
// checked per scenario.
module tb_gon_tag_sequencer;
  import gon_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] cfg_row_base = 4'd0;
  logic [4:0] cfg_row_cnt = 5'd0;
  logic [3:0] cfg_col_base = 4'd0;
  logic [4:0] cfg_col_cnt = 5'd0;
  logic [7:0] cfg_passes = 8'd0;
  logic       busy;
  logic       done;
`ifdef GON_TAG_SEQ_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_tag_cnt;
`endif

  gon_tag_sequencer_if #(.ROW_TAG_WIDTH(4), .COL_TAG_WIDTH(4)) tif ();

  gon_tag_sequencer #(.ROW_TAG_WIDTH(4), .COL_TAG_WIDTH(4), .PASS_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_row_base(cfg_row_base), .cfg_row_cnt(cfg_row_cnt),
    .cfg_col_base(cfg_col_base), .cfg_col_cnt(cfg_col_cnt),
    .cfg_passes(cfg_passes), .tags(tif), .busy(busy), .done(done)
`ifdef GON_TAG_SEQ_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_tag_cnt(perf_tag_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  gon_tag_pair_t exp_q[$];
  gon_tag_pair_t obs_q[$];
  gon_tag_pair_t cmp_e;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Expected stream: pass outer, row middle, col inner; tags wrap at 4 bits.
  task automatic build_q(input logic [3:0] rb, input int rc, input logic [3:0] cb,
                         input int cc, input int ps);
    gon_tag_pair_t t;
    for (int p = 0; p < ps; p++)
      for (int r = 0; r < rc; r++)
        for (int c = 0; c < cc; c++) begin
          t.row = rb + 4'(r);
          t.col = cb + 4'(c);
          exp_q.push_back(t);
        end
  endtask

  // Compare process: every write must match the head of the expected stream.
  always @(negedge clk) begin
    if (reset) begin
      if (tif.tags_wr_en) begin
        obs_q.push_back({tif.col_tag, tif.row_tag});
        check("write_while_full", int'(tif.tags_full), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", int'({tif.col_tag, tif.row_tag}), -1);
        end else begin
          cmp_e = exp_q.pop_front();
          check("tag_pair", int'({tif.col_tag, tif.row_tag}), int'(cmp_e));
        end
      end
      if (busy) check("busy_done_overlap", int'(done), 0);
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_row_tag"}, int'(tif.row_tag), 0);
    check({tag, "_col_tag"}, int'(tif.col_tag), 0);
    check({tag, "_wr_en"}, int'(tif.tags_wr_en), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  // Runs one job; optional stall window, abort point and reset point.
  task automatic run_job(input logic [3:0] rb, input int rc, input logic [3:0] cb,
                         input int cc, input int ps, input int stall_after,
                         input int stall_len, input int abort_after, input int reset_after,
                         output int start_cyc, output int last_wr_cyc, output int done_cyc,
                         output int nwr, output int busy_cnt, output int stall_cnt);
    bit finished;
    int abort_cyc;
    exp_q.delete();
    obs_q.delete();
    build_q(rb, rc, cb, cc, ps);
    @(posedge clk); #1;
    cfg_row_base = rb; cfg_row_cnt = 5'(rc);
    cfg_col_base = cb; cfg_col_cnt = 5'(cc);
    cfg_passes = 8'(ps);
    start = 1'b1; abort = 1'b0; tif.tags_full = 1'b0;
    start_cyc = cyc;
    last_wr_cyc = -1; done_cyc = -1; nwr = 0; busy_cnt = 0; stall_cnt = 0;
    abort_cyc = -1; finished = 1'b0;
    for (int i = 0; i < 300 && !finished; i++) begin
      @(negedge clk);
      if (tif.tags_wr_en) begin nwr++; last_wr_cyc = cyc; end
      if (busy) busy_cnt++;
      if (tif.tags_full && busy) begin
        stall_cnt++;
        check("stall_no_write", int'(tif.tags_wr_en), 0);
        if (exp_q.size() > 0)
          check("stall_hold_tag", int'({tif.col_tag, tif.row_tag}), int'(exp_q[0]));
      end
      if (done) begin
        done_cyc = cyc; finished = 1'b1;
      end else if (abort_cyc >= 0) begin
        finished = 1'b1;
      end else if (reset_after >= 0 && nwr == reset_after) begin
`ifdef GON_TAG_SEQ_PERF_EN
        check("perf_stall_before_reset", int'(perf_stall_cnt), stall_cnt);
        check("perf_tag_before_reset", int'(perf_tag_cnt), nwr - 1);
`endif
        #2 reset = 1'b0;
        #1 check_outputs_zero("async_reset");
`ifdef GON_TAG_SEQ_PERF_EN
        check("perf_stall_after_reset", int'(perf_stall_cnt), 0);
        check("perf_tag_after_reset", int'(perf_tag_cnt), 0);
`endif
        finished = 1'b1;
      end
      if (!finished) begin
        @(posedge clk); #1;
        start = 1'b0;
        tif.tags_full = (stall_len > 0 && nwr >= stall_after && stall_cnt < stall_len);
        if (abort_after >= 0 && nwr == abort_after) begin
          abort = 1'b1; abort_cyc = cyc;
        end
      end
    end
    check("job_finished", int'(finished), 1);
    tif.tags_full = 1'b0;
  endtask

  initial begin
    int s, lw, d, n, b, st;
    logic [7:0] c1_tbl [6];
    logic [3:0] c3_col [6];
    c1_tbl = '{8'h52, 8'h62, 8'h72, 8'h53, 8'h63, 8'h73};
    c3_col = '{4'd14, 4'd15, 4'd0, 4'd14, 4'd15, 4'd0};
    tif.tags_full = 1'b0;

    // Model pins: hand-computed entries of the expected stream.
    build_q(4'd2, 2, 4'd5, 3, 1);
    check("model_len", exp_q.size(), 6);
    check("model_entry3", int'(exp_q[3]), 8'h53);
    exp_q.delete();
    build_q(4'd9, 1, 4'd14, 3, 2);
    check("model_wrap_col", int'(exp_q[2].col), 0);
    check("model_wrap_len", exp_q.size(), 6);
    exp_q.delete();

    // Reset state, during and after reset.
    #3 check_outputs_zero("reset_hold");
    @(negedge clk); reset = 1'b1;
    @(negedge clk); check_outputs_zero("after_reset");

    // Basic 2x3 job, no stall.
    run_job(4'd2, 2, 4'd5, 3, 1, -1, 0, -1, -1, s, lw, d, n, b, st);
    check("c1_writes", n, 6);
    check("c1_first_to_last", lw - s, 6);
    check("c1_done_latency", d - lw, 1);
    check("c1_busy_cycles", b, 6);
    check("c1_queue_empty", exp_q.size(), 0);
    check("c1_obs_len", obs_q.size(), 6);
    for (int i = 0; i < 6 && i < obs_q.size(); i++)
      check("c1_literal_tag", int'(obs_q[i]), int'(c1_tbl[i]));

    // Same job with four full cycles after the second write.
    run_job(4'd2, 2, 4'd5, 3, 1, 2, 4, -1, -1, s, lw, d, n, b, st);
    check("c2_writes", n, 6);
    check("c2_stall_cycles", st, 4);
    check("c2_done_delay", d - s, 11);
    check("c2_queue_empty", exp_q.size(), 0);
    for (int i = 0; i < 6 && i < obs_q.size(); i++)
      check("c2_literal_tag", int'(obs_q[i]), int'(c1_tbl[i]));
`ifdef GON_TAG_SEQ_PERF_EN
    check("c2_perf_stall", int'(perf_stall_cnt), 4);
    check("c2_perf_tag", int'(perf_tag_cnt), 6);
`endif

    // Col tag wrap-around over two passes.
    run_job(4'd9, 1, 4'd14, 3, 2, -1, 0, -1, -1, s, lw, d, n, b, st);
    check("c3_writes", n, 6);
    check("c3_done_latency", d - lw, 1);
    for (int i = 0; i < 6 && i < obs_q.size(); i++)
      check("c3_col_tag", int'(obs_q[i].col), int'(c3_col[i]));

    // Zero col count: done next cycle, nothing written.
    run_job(4'd0, 2, 4'd0, 0, 1, -1, 0, -1, -1, s, lw, d, n, b, st);
    check("c4_writes", n, 0);
    check("c4_done_latency", d - s, 1);
    check("c4_busy_cycles", b, 0);

    // Zero pass count.
    run_job(4'd3, 1, 4'd3, 1, 0, -1, 0, -1, -1, s, lw, d, n, b, st);
    check("c4b_writes", n, 0);
    check("c4b_done_latency", d - s, 1);

    // Abort after the third write of a 12-tag job.
    run_job(4'd1, 3, 4'd0, 4, 1, -1, 0, 3, -1, s, lw, d, n, b, st);
    check("c5_writes", n, 3);
    check("c5_no_done", d, -1);
    // New job started the cycle right after abort.
    run_job(4'd2, 2, 4'd5, 3, 1, -1, 0, -1, -1, s, lw, d, n, b, st);
    check("c5_restart_writes", n, 6);
    check("c5_restart_latency", lw - s, 6);
    check("c5_restart_done", d - lw, 1);

    // Reset mid-job (with a short stall), then a fresh job.
    run_job(4'd4, 2, 4'd8, 4, 2, 1, 2, -1, 5, s, lw, d, n, b, st);
    check("c6_writes_before_reset", n, 5);
    check("c6_stalls_before_reset", st, 2);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); check_outputs_zero("c6_released");
    run_job(4'd4, 2, 4'd8, 4, 2, -1, 0, -1, -1, s, lw, d, n, b, st);
    check("c6_fresh_writes", n, 16);
    check("c6_fresh_latency", lw - s, 16);
    check("c6_fresh_queue_empty", exp_q.size(), 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
